// File: rtl/psum_drain_pkg.sv
// Shared definitions for the psum drain: FSM states, default datapath widths
// and the frame-size helper.
package psum_drain_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } drain_state_t;

  // Default widths, shared with the MAC datapath that fills the output FIFO.
  localparam int unsigned PSUM_DATA_WIDTH = 16;
  localparam int unsigned PSUM_ADDR_WIDTH = 8;

  // Number of result beats in one frame.
  function automatic int unsigned frame_beats(input int unsigned row_len,
                                              input int unsigned num_rows);
    return row_len * num_rows;
  endfunction

endpackage

// File: rtl/psum_drain_if.sv
// Result stream of the psum drain: valid/ready beats with address and
// row/frame markers. master = drain, slave = result memory / host port.
interface psum_drain_if
  import psum_drain_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = PSUM_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = PSUM_ADDR_WIDTH
) ();

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic                  out_row_last;
  logic                  out_frame_last;

  modport master (
    output out_valid, out_data, out_addr, out_row_last, out_frame_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_addr, out_row_last, out_frame_last,
    output out_ready
  );

endinterface

// File: rtl/psum_drain_skid_buf.sv
// Two-entry holding FIFO between the output-FIFO read port and the result
// stream. The caller guarantees no push when full and no pop when empty.
module drain_skid_buf #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;

  // Storage, pointers and occupancy; flush empties without touching storage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/psum_drain.sv
// psum_drain: pops one ROW_LEN x NUM_ROWS frame of partial sums from the
// convolution output FIFO and presents them as an addressed valid/ready
// result stream with row/frame markers.
// Optional feature macro: PSUM_RELU_EN (clamp negative psums to 0 on capture).
module psum_drain
  import psum_drain_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = PSUM_DATA_WIDTH,
  parameter int unsigned ROW_LEN    = 4,
  parameter int unsigned NUM_ROWS   = 4,
  parameter int unsigned ADDR_WIDTH = PSUM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  clr,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  fifo_empty,
  output logic                  fifo_ren,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  busy,
  output logic                  done,
  psum_drain_if.master          res
);

  localparam int unsigned FRAME_BEATS = frame_beats(ROW_LEN, NUM_ROWS);
  localparam int unsigned BW = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
  localparam int unsigned IW = $clog2(FRAME_BEATS + 1);
  localparam int unsigned CW = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam int unsigned RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  drain_state_t          state, state_nxt;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [BW-1:0]         beat_q;
  logic [CW-1:0]         col_q;
  logic [RW-1:0]         row_q;
  logic [IW-1:0]         iss_q;
  logic                  infl_q;

  logic [DATA_WIDTH-1:0] push_data;
  logic [DATA_WIDTH-1:0] buf_head;
  logic [1:0]            buf_cnt;
  logic                  out_valid;
  logic                  hs;
  logic                  row_last;
  logic                  frame_end;
  logic [2:0]            fill_next;

  assign out_valid = (buf_cnt != 2'd0);
  assign hs        = out_valid && res.out_ready;
  assign row_last  = (col_q == CW'(ROW_LEN - 1));
  assign frame_end = hs && row_last && (row_q == RW'(NUM_ROWS - 1));

  // Occupancy is counted after this cycle's pop so a word can be requested
  // every cycle while the consumer keeps accepting; the buffer still never
  // holds more than two words once the in-flight read lands.
  assign fill_next = 3'(buf_cnt) + {2'b00, infl_q} - {2'b00, hs};

`ifdef PSUM_RELU_EN
  assign push_data = fifo_dout[DATA_WIDTH-1] ? '0 : fifo_dout;
`else
  assign push_data = fifo_dout;
`endif

  // Read issue: only in RUN, never on empty, never beyond the frame.
  always_comb begin
    fifo_ren = 1'b0;
    if (state == RUN && !clr && !fifo_empty &&
        iss_q < IW'(FRAME_BEATS) && fill_next < 3'd2)
      fifo_ren = 1'b1;
  end

  // Next-state logic; clr wins over everything including start.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (frame_end) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clr) state_nxt = IDLE;
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Base latch, issue/beat/column/row counters and in-flight read flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      base_q <= '0;
      beat_q <= '0;
      col_q  <= '0;
      row_q  <= '0;
      iss_q  <= '0;
      infl_q <= 1'b0;
    end else if (clr) begin
      beat_q <= '0;
      col_q  <= '0;
      row_q  <= '0;
      iss_q  <= '0;
      infl_q <= 1'b0;
    end else begin
      infl_q <= fifo_ren;
      if (state == IDLE && start) begin
        base_q <= base_addr;
        beat_q <= '0;
        col_q  <= '0;
        row_q  <= '0;
        iss_q  <= '0;
      end else begin
        if (fifo_ren) iss_q <= iss_q + IW'(1);
        if (hs) begin
          beat_q <= beat_q + BW'(1);
          if (row_last) begin
            col_q <= '0;
            row_q <= row_q + RW'(1);
          end else begin
            col_q <= col_q + CW'(1);
          end
        end
      end
    end
  end

  drain_skid_buf #(
    .WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (clr),
    .push      (infl_q),
    .push_data (push_data),
    .pop       (hs),
    .head      (buf_head),
    .count     (buf_cnt)
  );

  assign res.out_valid      = out_valid;
  assign res.out_data       = out_valid ? buf_head : '0;
  assign res.out_addr       = out_valid ? base_q + ADDR_WIDTH'(beat_q) : '0;
  assign res.out_row_last   = out_valid && row_last;
  assign res.out_frame_last = out_valid && (beat_q == BW'(FRAME_BEATS - 1));

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_psum_drain.sv
// Self-checking bench for psum_drain: behavioural output-FIFO source, a
// frame-level reference model of the expected result beats, and directed
// frames with randomized data, base addresses and consumer back-pressure.
module tb_psum_drain;
  import psum_drain_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic        clr;
  logic [7:0]  base_addr;
  logic        fifo_empty = 1'b1;
  logic        fifo_ren;
  logic [15:0] fifo_dout = '0;
  logic        busy;
  logic        done;

  psum_drain_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) res ();

  psum_drain #(
    .DATA_WIDTH (16),
    .ROW_LEN    (4),
    .NUM_ROWS   (4),
    .ADDR_WIDTH (8)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .clr        (clr),
    .base_addr  (base_addr),
    .fifo_empty (fifo_empty),
    .fifo_ren   (fifo_ren),
    .fifo_dout  (fifo_dout),
    .busy       (busy),
    .done       (done),
    .res        (res)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Words the source FIFO will deliver (written only by the stimulus block).
  logic [15:0] pend[$];
  int          feed_mode = 0;   // 0: all at once, 1: one word every 3 cycles
  int          feed_gen  = 0;

  // Behavioural output FIFO: registered read, flushed and reloaded on feed_gen.
  logic [15:0] fq[$];
  int          seen_gen = 0;
  int          pend_rd  = 0;
  int          tcnt     = 0;
  always @(posedge clk) begin
    if (feed_gen != seen_gen) begin
      seen_gen = feed_gen;
      fq.delete();
      pend_rd = 0;
      tcnt    = 0;
    end else if (fifo_ren && fq.size() > 0) begin
      fifo_dout <= fq.pop_front();
    end
    if (pend_rd < pend.size()) begin
      if (feed_mode == 0) begin
        while (pend_rd < pend.size()) begin
          fq.push_back(pend[pend_rd]);
          pend_rd++;
        end
      end else begin
        tcnt++;
        if (tcnt == 3) begin
          tcnt = 0;
          fq.push_back(pend[pend_rd]);
          pend_rd++;
        end
      end
    end
    fifo_empty <= (fq.size() == 0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference beat: {data, addr, row_last, frame_last} for beat i of a frame.
  function automatic logic [25:0] exp_beat(input logic [15:0] w, input logic [7:0] base,
                                           input int i);
    logic [15:0] d;
    logic [7:0]  a;
    logic        rl;
    logic        fl;
    d = w;
`ifdef PSUM_RELU_EN
    if ($signed(w) < 0) d = 16'h0000;
`endif
    a  = 8'((int'(base) + i) % 256);
    rl = ((i % 4) == 3);
    fl = (i == 15);
    return {d, a, rl, fl};
  endfunction

  // kind 0: words 1..16; 1: random; 2: random led by 0xFFFF, 0x0005, 0x8000.
  task automatic load(input int mode, input int kind);
    pend.delete();
    for (int i = 0; i < 16; i++) begin
      if (kind == 0) pend.push_back(16'(i + 1));
      else           pend.push_back(16'($urandom));
    end
    if (kind == 2) begin
      pend[0] = 16'hFFFF;
      pend[1] = 16'h0005;
      pend[2] = 16'h8000;
    end
    feed_mode = mode;
    feed_gen++;
  endtask

  task automatic run_frame(input logic [7:0] base, input int rdy_pct, input int stop_after,
                           input bit tight, input bit glitch);
    int          k = 0;
    int          reads = 0;
    int          first_v = -1;
    int          last_hs = -1;
    int          gap = 0;
    logic [25:0] obs;
    logic [25:0] prev = '0;
    bit          stall = 0;
    bit          hs;
    @(posedge clk); #1;
    base_addr = base;
    start     = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(posedge clk); #1;
      start = glitch && (cyc == 5);
      if (glitch && cyc == 5) base_addr = base ^ 8'h55;
      res.out_ready = ($urandom_range(99) < rdy_pct);
      #1;
      if (cyc == 0) chk("busy_after_start", busy, 1);
      chk("no_early_done", done, 0);
      chk("ren_while_empty", fifo_ren & fifo_empty, 0);
      obs = {res.out_data, res.out_addr, res.out_row_last, res.out_frame_last};
      if (stall) chk("stall_hold", {res.out_valid, obs}, {1'b1, prev});
      if (res.out_valid) begin
        if (first_v < 0) first_v = cyc;
        chk("beat", obs, exp_beat(pend[k], base, k));
      end else if (first_v >= 0) begin
        gap++;
      end
      hs = res.out_valid && res.out_ready;
      if (fifo_ren) reads++;
      chk("outstanding_le2", 32'((reads - k - int'(hs)) <= 2), 1);
      stall = res.out_valid && !res.out_ready;
      prev  = obs;
      if (hs) begin
        last_hs = cyc;
        k++;
      end
      if (k == stop_after) break;
    end
    chk("handshakes", k, stop_after);
    if (stop_after == 16) begin
      chk("total_reads", reads, 16);
      @(posedge clk); #2;
      chk("done_pulse", {done, busy, res.out_valid}, 3'b110);
      @(posedge clk); #2;
      chk("back_to_idle", {done, busy}, 2'b00);
    end
    if (tight) begin
      chk("first_valid_cycle", first_v, 2);
      chk("last_hs_cycle", last_hs, 17);
      chk("no_gaps", gap, 0);
    end
  endtask

  initial begin
    rstn          = 1'b0;
    start         = 1'b0;
    clr           = 1'b0;
    base_addr     = '0;
    res.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_outputs",
        {fifo_ren, res.out_valid, res.out_row_last, res.out_frame_last, busy, done}, 6'b0);
    chk("rst_data", res.out_data, 0);
    chk("rst_addr", res.out_addr, 0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // Preloaded 1..16, always ready: back-to-back beats from 0x10.
    load(0, 0);
    run_frame(8'h10, 100, 16, 1, 0);

    // ReLU probe words plus random data, random stalls, ignored mid-frame start.
    load(0, 2);
    run_frame(8'($urandom), 50, 16, 0, 1);

    // Trickle feed: one word every third cycle.
    load(1, 1);
    run_frame(8'($urandom), 100, 16, 0, 0);

    // Address wrap from 0xFE.
    load(0, 1);
    run_frame(8'hFE, 60, 16, 0, 0);

    // Abort with clr after beat 5, then a fresh frame.
    load(0, 1);
    run_frame(8'($urandom), 100, 6, 0, 0);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    #1;
    chk("clr_idle", {busy, done, res.out_valid, fifo_ren}, 4'b0);
    chk("clr_addr", res.out_addr, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #2;
      chk("clr_no_done", done, 0);
    end
    load(0, 1);
    run_frame(8'h40, 100, 16, 1, 0);

    // Asynchronous reset mid-frame, then a fresh frame.
    load(0, 1);
    run_frame(8'($urandom), 70, 6, 0, 0);
    rstn = 1'b0;
    #1;
    chk("arst_outputs",
        {fifo_ren, res.out_valid, res.out_row_last, res.out_frame_last, busy, done}, 6'b0);
    chk("arst_data", res.out_data, 0);
    chk("arst_addr", res.out_addr, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #2;
    chk("arst_no_done", done, 0);
    load(0, 1);
    run_frame(8'hA0, 100, 16, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
